// File: rtl/oled_page_scheduler_if.sv
// Purpose: bundles the control, frame-BRAM and SPI byte-stream signals of the OLED page scheduler.
// Ports:   master = host/display side (drives en, dirty strobes, BRAM data, spi_ready);
//          slave  = scheduler (drives BRAM address, SPI byte stream, status).
interface oled_page_scheduler_if #(
    parameter int NUM_PAGES = 4,
    parameter int COLS      = 128,
    parameter int ADDR_W    = 10
);
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

    logic                 en;
    logic                 dirty_set;
    logic [PAGE_W-1:0]    dirty_page;
    logic                 full_refresh;
    logic [ADDR_W-1:0]    bram_addr;
    logic [7:0]           bram_data;
    logic [7:0]           spi_byte;
    logic                 spi_dc;
    logic                 spi_valid;
    logic                 spi_ready;
    logic                 busy;
    logic                 fin;
    logic [NUM_PAGES-1:0] dirty;

    modport master (
        output en, dirty_set, dirty_page, full_refresh, bram_data, spi_ready,
        input  bram_addr, spi_byte, spi_dc, spi_valid, busy, fin, dirty
    );

    modport slave (
        input  en, dirty_set, dirty_page, full_refresh, bram_data, spi_ready,
        output bram_addr, spi_byte, spi_dc, spi_valid, busy, fin, dirty
    );
endinterface

// File: rtl/oled_page_scheduler.sv
// Purpose: incremental OLED refresh; sends addressing commands then COLS BRAM bytes for each dirty page, lowest index first.
// Latency: EN & dirty -> first byte offered 2 cycles later; each data byte costs RD/WT/DT (3 cycles) minimum.
// Backpressure: every offered byte is held (value and DC stable) until spi_ready accepts it; EN low only parks after the current page.
// Ports: clk, rst (sync, active-high), bus = oled_page_scheduler_if.slave (control strobes, BRAM port, SPI byte stream, status).
module oled_page_scheduler #(
    parameter int NUM_PAGES = 4,
    parameter int COLS      = 128,
    parameter int ADDR_W    = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    oled_page_scheduler_if.slave  bus
);
    localparam int PAGE_W = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_PICK, S_C0, S_C1, S_C2, S_C3, S_C4, S_C5, S_RD, S_WT, S_DT, S_NX
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NUM_PAGES-1:0] bitmap;
    logic [NUM_PAGES-1:0] bitmap_nxt;
    logic [PAGE_W-1:0]    pg;
    logic [PAGE_W-1:0]    pick_idx;
    logic [COL_W-1:0]     col;
    logic [ADDR_W-1:0]    bram_addr_q;
    logic [7:0]           data_q;
    logic                 accept;
    logic                 last_col;

    // pg*COLS + col, truncated; reduces to {pg, col} when COLS is a power of two.
    function automatic logic [ADDR_W-1:0] page_addr(input logic [PAGE_W-1:0] p,
                                                    input logic [COL_W-1:0]  c);
        logic [31:0] a;
        a = 32'(p) * 32'(COLS) + 32'(c);
        return a[ADDR_W-1:0];
    endfunction

    assign accept   = bus.spi_valid && bus.spi_ready;
    assign last_col = (col == COL_W'(COLS - 1));

    // Lowest dirty index: scan downward so the lowest set bit is written last.
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_PAGES - 1; i >= 0; i--) begin
            if (bitmap[i]) pick_idx = PAGE_W'(i);
        end
    end

    // Sets are OR-ed after the PICK clear so a same-cycle set re-queues the page.
    always_comb begin
        logic [NUM_PAGES-1:0] clr;
        logic [NUM_PAGES-1:0] set;
        clr = '0;
        set = '0;
        if (state == S_PICK) clr = NUM_PAGES'(1) << pick_idx;
        if (bus.full_refresh) set = '1;
        else if (bus.dirty_set) set = NUM_PAGES'(1) << bus.dirty_page;
        bitmap_nxt = (bitmap & ~clr) | set;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.en && (|bitmap)) state_nxt = S_PICK;
            S_PICK: state_nxt = S_C0;
            S_C0:   if (accept) state_nxt = S_C1;
            S_C1:   if (accept) state_nxt = S_C2;
            S_C2:   if (accept) state_nxt = S_C3;
            S_C3:   if (accept) state_nxt = S_C4;
            S_C4:   if (accept) state_nxt = S_C5;
            S_C5:   if (accept) state_nxt = S_RD;
            S_RD:   state_nxt = S_WT;
            S_WT:   state_nxt = S_DT;
            S_DT:   if (accept) state_nxt = last_col ? S_NX : S_RD;
            S_NX:   state_nxt = (bus.en && (|bitmap)) ? S_PICK : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers; the BRAM address is loaded on entry to RD so it is stable
    // for the read edge at the end of RD, and data lands in data_q at the end of WT.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitmap      <= '0;
            pg          <= '0;
            col         <= '0;
            bram_addr_q <= '0;
            data_q      <= '0;
        end else begin
            bitmap <= bitmap_nxt;
            if (state == S_PICK) pg <= pick_idx;
            if (state == S_C5 && accept) begin
                col         <= '0;
                bram_addr_q <= page_addr(pg, '0);
            end
            if (state == S_DT && accept) begin
                if (last_col) begin
                    col <= '0;
                end else begin
                    col         <= col + COL_W'(1);
                    bram_addr_q <= page_addr(pg, col + COL_W'(1));
                end
            end
            if (state == S_WT) data_q <= bus.bram_data;
        end
    end

    // Outputs decode from registered state only, so they hold steady while a byte waits.
    always_comb begin
        bus.spi_valid = 1'b0;
        bus.spi_dc    = 1'b0;
        bus.spi_byte  = 8'h00;
        case (state)
            S_C0: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'h22;         end
            S_C1: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'(pg);        end
            S_C2: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'(pg);        end
            S_C3: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'h21;         end
            S_C4: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'h00;         end
            S_C5: begin bus.spi_valid = 1'b1; bus.spi_byte = 8'(COLS - 1);  end
            S_DT: begin bus.spi_valid = 1'b1; bus.spi_dc = 1'b1; bus.spi_byte = data_q; end
            default: ;
        endcase
        bus.busy      = (state != S_IDLE);
        bus.fin       = (state == S_NX) && (bitmap == '0);
        bus.dirty     = bitmap;
        bus.bram_addr = bram_addr_q;
    end
endmodule

// File: tb/tb_oled_page_scheduler.sv
`timescale 1ns/1ps
module tb_oled_page_scheduler;
    localparam int NP = 4;
    localparam int NC = 128;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    oled_page_scheduler_if #(.NUM_PAGES(NP), .COLS(NC), .ADDR_W(AW)) b();
    oled_page_scheduler #(.NUM_PAGES(NP), .COLS(NC), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) b.bram_data <= mem[b.bram_addr];

    int tests = 0;
    int fails = 0;
    int fin_cnt = 0;
    int acc_cnt = 0;
    int stall_seen = 0;
    int stall_mode = 0;
    logic [8:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_page(input int p);
        q.push_back({1'b0, 8'h22});
        q.push_back({1'b0, 8'(p)});
        q.push_back({1'b0, 8'(p)});
        q.push_back({1'b0, 8'h21});
        q.push_back({1'b0, 8'h00});
        q.push_back({1'b0, 8'(NC - 1)});
        for (int c = 0; c < NC; c++) q.push_back({1'b1, mem[p*NC + c]});
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        repeat (3) tick();
        while ((b.busy || q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    // Ready driver: always high unless stall mode randomises it.
    initial begin
        b.spi_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            b.spi_ready = (stall_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pop on acceptance, hold-stability while stalled, FIN count.
    logic       hold_vld = 1'b0;
    logic [8:0] hold_val;
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                chk("valid_held", 32'(b.spi_valid), 32'd1);
                if (b.spi_valid) begin
                    chk("stall_stable", 32'({b.spi_dc, b.spi_byte}), 32'(hold_val));
                    stall_seen++;
                end
            end
            if (b.fin) fin_cnt++;
            if (b.spi_valid && b.spi_ready) begin
                acc_cnt++;
                hold_vld = 1'b0;
                if (q.size() == 0) begin
                    chk("sb_unexpected", 32'({b.spi_dc, b.spi_byte}), 32'h1ff);
                end else begin
                    chk("sb_byte", 32'({b.spi_dc, b.spi_byte}), 32'(q.pop_front()));
                end
            end else if (b.spi_valid) begin
                hold_vld = 1'b1;
                hold_val = {b.spi_dc, b.spi_byte};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin
        int base;
        int n;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 37 + 11);
        b.en = 1'b0;
        b.dirty_set = 1'b0;
        b.dirty_page = '0;
        b.full_refresh = 1'b0;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_valid", 32'(b.spi_valid), 32'd0);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_fin", 32'(b.fin), 32'd0);
        chk("rst_dirty", 32'(b.dirty), 32'd0);
        chk("rst_addr", 32'(b.bram_addr), 32'd0);
        chk("rst_byte", 32'(b.spi_byte), 32'd0);

        // Single page 2, with start latency checks
        b.en = 1'b1;
        push_page(2);
        fin_cnt = 0;
        tick();
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd2;
        tick();
        b.dirty_set = 1'b0;
        @(negedge clk);
        chk("lat_dirty", 32'(b.dirty), 32'b0100);
        chk("lat_idle_valid", 32'(b.spi_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_pick_busy", 32'(b.busy), 32'd1);
        chk("lat_pick_valid", 32'(b.spi_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_c0_valid", 32'(b.spi_valid), 32'd1);
        wait_done("t1_timeout", 2000);
        chk("t1_fin", 32'(fin_cnt), 32'd1);
        chk("t1_dirty", 32'(b.dirty), 32'd0);

        // Full refresh: four pages in order, one FIN
        fin_cnt = 0;
        base = acc_cnt;
        for (int p = 0; p < NP; p++) push_page(p);
        b.full_refresh = 1'b1;
        tick();
        b.full_refresh = 1'b0;
        wait_done("t2_timeout", 4000);
        chk("t2_bytes", 32'(acc_cnt - base), 32'(4 * (NC + 6)));
        chk("t2_fin", 32'(fin_cnt), 32'd1);

        // Random stalls on page 1
        fin_cnt = 0;
        stall_seen = 0;
        stall_mode = 1;
        push_page(1);
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd1;
        tick();
        b.dirty_set = 1'b0;
        wait_done("t3_timeout", 4000);
        stall_mode = 0;
        chk("t3_stalls_exercised", 32'(stall_seen > 0), 32'd1);
        chk("t3_fin", 32'(fin_cnt), 32'd1);

        // Set page 0 again on its own PICK cycle -> sent twice
        fin_cnt = 0;
        push_page(0);
        push_page(0);
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd0;
        tick();
        b.dirty_set = 1'b0;
        tick();
        chk("t4_in_pick_busy", 32'(b.busy), 32'd1);
        chk("t4_in_pick_valid", 32'(b.spi_valid), 32'd0);
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd0;
        tick();
        b.dirty_set = 1'b0;
        wait_done("t4_timeout", 3000);
        chk("t4_fin", 32'(fin_cnt), 32'd1);
        chk("t4_dirty", 32'(b.dirty), 32'd0);

        // EN dropped mid page 1 with page 3 pending
        fin_cnt = 0;
        push_page(1);
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd1;
        tick();
        b.dirty_page = 2'd3;
        tick();
        b.dirty_set = 1'b0;
        repeat (50) tick();
        b.en = 1'b0;
        wait_done("t5_timeout", 2000);
        repeat (10) tick();
        chk("t5_parked_busy", 32'(b.busy), 32'd0);
        chk("t5_dirty", 32'(b.dirty), 32'b1000);
        chk("t5_no_fin", 32'(fin_cnt), 32'd0);
        push_page(3);
        b.en = 1'b1;
        wait_done("t5b_timeout", 2000);
        chk("t5b_fin", 32'(fin_cnt), 32'd1);
        chk("t5b_dirty", 32'(b.dirty), 32'd0);

        // Reset during data byte 40 of page 2
        base = acc_cnt;
        push_page(2);
        b.dirty_set = 1'b1;
        b.dirty_page = 2'd2;
        tick();
        b.dirty_page = 2'd3;
        tick();
        b.dirty_set = 1'b0;
        n = 0;
        while (acc_cnt < base + 6 + 40 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("t6_reach_timeout", 32'(n < 2000), 32'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!b.spi_valid && n < 10);
        chk("t6_byte40_offered", 32'(b.spi_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        q.delete();
        chk("t6_valid", 32'(b.spi_valid), 32'd0);
        chk("t6_busy", 32'(b.busy), 32'd0);
        chk("t6_dirty", 32'(b.dirty), 32'd0);
        chk("t6_addr", 32'(b.bram_addr), 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
